// File: rtl/alu_op_sequencer.sv
// Purpose : per-Bennett-cycle sequencer that decodes a 3-bit ALU opcode into held
//           select/control lines and fires one ALU_O/A capture pulse at the Bennett peak.
// Latency : controls appear 1 clk after the first instFlag rise following acceptance; done
//           pulses 1 clk after the HOLD_CYCLES-th subsequent rise.
// Backpressure: op_ready is low from the clk after acceptance until the clk after done;
//           op_valid is ignored while an op is in flight.
//
// Ports:
//   clk, reset              system clock (shared with bennett_clock), async active-high reset
//   instFlag                Bennett cycle boundary flag; only its rising edge is used
//   clkpos/clkneg [WIDTH]   Bennett phases; peak = all clkpos high and all clkneg low
//   op_valid/op_code/op_ready  opcode handshake (0 ADD,1 SUB,2 SLT,3 AND,4 OR,5 PASSB,6 PCINC,7 IMM)
//   ALU_Control1/0, A_mux, B_mux1/0, Adder_Cin, SUB, STL, mux3_1/0   decoded ALU controls
//   ALU_O_Fclkpos, A_Fclkpos   single-clk capture pulse at the first peak of an op
//   busy, done, missed_peak    op status; missed_peak accompanies done when no peak was seen

module alu_op_sequencer #(
    parameter int WIDTH       = 13,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instFlag,
    input  logic [WIDTH-1:0] clkpos,
    input  logic [WIDTH-1:0] clkneg,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    output logic             op_ready,
    output logic             ALU_Control0,
    output logic             ALU_Control1,
    output logic             A_mux,
    output logic             B_mux0,
    output logic             B_mux1,
    output logic             Adder_Cin,
    output logic             SUB,
    output logic             STL,
    output logic             mux3_0,
    output logic             mux3_1,
    output logic             ALU_O_Fclkpos,
    output logic             A_Fclkpos,
    output logic             busy,
    output logic             done,
    output logic             missed_peak
);

    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Field order matches the decode table columns.
    typedef struct packed {
        logic c1;
        logic c0;
        logic a_mux;
        logic b_mux1;
        logic b_mux0;
        logic cin;
        logic sub;
        logic stl;
        logic mux3_1;
        logic mux3_0;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [2:0] code);
        ctrl_t c;
        case (code)
            3'd0:    c = 10'b10_1_11_000_00;  // ADD
            3'd1:    c = 10'b10_1_11_110_00;  // SUB
            3'd2:    c = 10'b10_1_11_111_00;  // SLT
            3'd3:    c = 10'b00_1_11_000_00;  // AND
            3'd4:    c = 10'b01_1_11_000_00;  // OR
            3'd5:    c = 10'b11_0_11_000_00;  // PASSB
            3'd6:    c = 10'b10_0_00_100_01;  // PCINC
            default: c = 10'b11_0_00_000_10;  // IMM
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         opcode_q, opcode_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               fired_q, fired_d;
    logic               pulse_q, pulse_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               missed_q, missed_d;
    logic               inst_flag_q;

    logic               rise;
    logic               peak;
    logic               last_rise;

    assign rise      = instFlag & ~inst_flag_q;
    assign peak      = (&clkpos) & ~(|clkneg);
    assign last_rise = rise && (hold_cnt_q == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        ctrl_d     = ctrl_q;
        hold_cnt_d = hold_cnt_q;
        fired_d    = fired_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        pulse_d    = 1'b0;
        done_d     = 1'b0;
        missed_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A rise coinciding with acceptance is deliberately not looked at here;
                // ARM only reacts to rises it samples itself.
                if (op_valid && ready_q) begin
                    opcode_d = op_code;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                if (rise) begin
                    ctrl_d     = decode(opcode_q);
                    hold_cnt_d = CNT_W'(HOLD_CYCLES);
                    fired_d    = 1'b0;
                    state_d    = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // Never fire on the clk whose rise tears the controls down, so the
                // capture pulse can never overlap a control change.
                if (peak && !fired_q && !last_rise) begin
                    pulse_d = 1'b1;
                    fired_d = 1'b1;
                end
                if (rise) begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                    if (last_rise) begin
                        ctrl_d   = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        missed_d = ~fired_q;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                ctrl_d  = '0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            ctrl_q      <= '0;
            hold_cnt_q  <= '0;
            fired_q     <= 1'b0;
            pulse_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            missed_q    <= 1'b0;
            // Reset high so an instFlag already high at release is not seen as a rise.
            inst_flag_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            ctrl_q      <= ctrl_d;
            hold_cnt_q  <= hold_cnt_d;
            fired_q     <= fired_d;
            pulse_q     <= pulse_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            missed_q    <= missed_d;
            inst_flag_q <= instFlag;
        end
    end

    assign op_ready      = ready_q;
    assign ALU_Control1  = ctrl_q.c1;
    assign ALU_Control0  = ctrl_q.c0;
    assign A_mux         = ctrl_q.a_mux;
    assign B_mux1        = ctrl_q.b_mux1;
    assign B_mux0        = ctrl_q.b_mux0;
    assign Adder_Cin     = ctrl_q.cin;
    assign SUB           = ctrl_q.sub;
    assign STL           = ctrl_q.stl;
    assign mux3_1        = ctrl_q.mux3_1;
    assign mux3_0        = ctrl_q.mux3_0;
    assign ALU_O_Fclkpos = pulse_q;
    assign A_Fclkpos     = pulse_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign missed_peak   = missed_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose : directed bench for alu_op_sequencer with a 16-clk Bennett phase generator
//           and a small ALU model fed by the decoded controls at each capture pulse.
// Latency : checks sampled 1 time unit after each falling clk edge.
// Backpressure: op_valid held one clk per request; busy-time requests are expected to drop.

module tb_alu_op_sequencer;

    localparam int W = 13;
    localparam int P = 16;

    logic clk;
    logic reset;
    logic instFlag;
    logic [W-1:0] clkpos, clkneg;
    logic op_valid, op_valid2;
    logic [2:0] op_code, op_code2;

    logic op_ready, c0, c1, amux, bm0, bm1, cin, sub, stl, m30, m31, alu_p, a_p, busy, done, missed;
    logic op_ready2, c0_2, c1_2, amux2, bm0_2, bm1_2, cin2, sub2, stl2, m30_2, m31_2;
    logic alu_p2, a_p2, busy2, done2, missed2;
    logic [9:0] ctrl, ctrl2;

    assign ctrl  = {c1, c0, amux, bm1, bm0, cin, sub, stl, m31, m30};
    assign ctrl2 = {c1_2, c0_2, amux2, bm1_2, bm0_2, cin2, sub2, stl2, m31_2, m30_2};

    alu_op_sequencer #(.WIDTH(W), .HOLD_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .instFlag(instFlag), .clkpos(clkpos), .clkneg(clkneg),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .ALU_Control0(c0), .ALU_Control1(c1), .A_mux(amux), .B_mux0(bm0), .B_mux1(bm1),
        .Adder_Cin(cin), .SUB(sub), .STL(stl), .mux3_0(m30), .mux3_1(m31),
        .ALU_O_Fclkpos(alu_p), .A_Fclkpos(a_p), .busy(busy), .done(done), .missed_peak(missed)
    );

    alu_op_sequencer #(.WIDTH(W), .HOLD_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .instFlag(instFlag), .clkpos(clkpos), .clkneg(clkneg),
        .op_valid(op_valid2), .op_code(op_code2), .op_ready(op_ready2),
        .ALU_Control0(c0_2), .ALU_Control1(c1_2), .A_mux(amux2), .B_mux0(bm0_2), .B_mux1(bm1_2),
        .Adder_Cin(cin2), .SUB(sub2), .STL(stl2), .mux3_0(m30_2), .mux3_1(m31_2),
        .ALU_O_Fclkpos(alu_p2), .A_Fclkpos(a_p2), .busy(busy2), .done(done2), .missed_peak(missed2)
    );

    int checks = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bennett phase generator: instFlag high for phases 0-1, peak during phases 7-9.
    int   ph;
    logic hole;

    task automatic drive_bennett();
        instFlag = (ph < 2);
        if (ph >= 7 && ph <= 9) begin
            clkpos = '1;
            clkneg = '0;
        end else begin
            clkpos = '0;
            clkneg = '1;
        end
        if (hole) clkpos[3] = 1'b0;
    endtask

    initial begin
        ph   = 4;
        hole = 1'b0;
        drive_bennett();
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % P;
            drive_bennett();
        end
    end

    // Reference ALU driven by the decoded control lines.
    function automatic logic [15:0] alu_model(input logic [9:0] c, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [15:0] opa, opb, sum, r;
        opa = c[7] ? a : 16'd0;
        opb = (c[6:5] == 2'b11) ? b : 16'd0;
        sum = opa + (c[3] ? ~opb : opb) + {15'd0, c[4]};
        if (c[2]) sum = {15'd0, sum[15]};
        case (c[9:8])
            2'b10:   r = sum;
            2'b00:   r = opa & opb;
            2'b01:   r = opa | opb;
            default: r = opb;
        endcase
        return r;
    endfunction

    int pulse_cnt = 0, pulse2_cnt = 0, done_cnt = 0, done2_cnt = 0, pair_bad = 0;
    logic [15:0] a_val, b_val, alu_res;

    always @(negedge clk) begin
        if (alu_p) begin
            pulse_cnt = pulse_cnt + 1;
            alu_res   = alu_model(ctrl, a_val, b_val);
        end
        if (alu_p2) pulse2_cnt = pulse2_cnt + 1;
        if (done)   done_cnt   = done_cnt + 1;
        if (done2)  done2_cnt  = done2_cnt + 1;
        if ((alu_p !== a_p) || (alu_p2 !== a_p2)) pair_bad = pair_bad + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ph(input int target);
        int n;
        n = 0;
        while (ph != target && n < 64) begin
            tick();
            n++;
        end
        if (ph != target) begin
            checks++;
            failures++;
            $display("FAIL wait_ph timeout: phase=%0d required=%0d", ph, target);
        end
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_valid2 = 1'b0; op_code2 = 3'd0;
        a_val = 16'd0; b_val = 16'd0;
        repeat (3) tick();
        checks++;
        if (op_ready !== 1'b1 || op_ready2 !== 1'b1) begin
            failures++; $display("FAIL reset_op_ready: got %b/%b required 1/1", op_ready, op_ready2);
        end
        checks++;
        if ({ctrl, alu_p, a_p, busy, done, missed} !== 15'd0) begin
            failures++; $display("FAIL reset_outputs: got %b required 0", {ctrl, alu_p, a_p, busy, done, missed});
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 3 * P; i++) begin
            tick();
            if (op_ready !== 1'b1 || ctrl !== 10'd0 || ctrl2 !== 10'd0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL idle_stable: bad cycles=%0d required 0", bad);
        end
        checks++;
        if (done_cnt != 0 || pulse_cnt != 0 || done2_cnt != 0 || pulse2_cnt != 0) begin
            failures++; $display("FAIL idle_no_events: done=%0d pulse=%0d required 0", done_cnt, pulse_cnt);
        end
    endtask

    task automatic test_add();
        int p0;
        wait_ph(4);
        a_val = 16'd1; b_val = 16'd2;
        op_valid = 1'b1; op_code = 3'd0;
        tick();
        op_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || op_ready !== 1'b0 || ctrl !== 10'd0) begin
            failures++; $display("FAIL add_accept: busy=%b ready=%b ctrl=%b required 1 0 0", busy, op_ready, ctrl);
        end
        wait_ph(0);
        checks++;
        if (ctrl !== 10'd0) begin
            failures++; $display("FAIL add_arm_hold: ctrl=%b required 0", ctrl);
        end
        p0 = pulse_cnt;
        tick();
        checks++;
        if (ctrl !== 10'b1011100000) begin
            failures++; $display("FAIL add_ctrl: got %b required 1011100000", ctrl);
        end
        wait_ph(0);
        checks++;
        if (done !== 1'b0 || ctrl !== 10'b1011100000) begin
            failures++; $display("FAIL add_pre_done: done=%b ctrl=%b required 0 1011100000", done, ctrl);
        end
        tick();
        checks++;
        if ({done, missed, busy, op_ready, ctrl} !== {4'b1000, 10'd0}) begin
            failures++; $display("FAIL add_done: got %b required 1000_0000000000", {done, missed, busy, op_ready, ctrl});
        end
        tick();
        checks++;
        if (done !== 1'b0 || op_ready !== 1'b1) begin
            failures++; $display("FAIL add_after_done: done=%b ready=%b required 0 1", done, op_ready);
        end
        checks++;
        if (pulse_cnt - p0 != 1 || pair_bad != 0) begin
            failures++; $display("FAIL add_pulse: count=%0d pair_bad=%0d required 1 0", pulse_cnt - p0, pair_bad);
        end
        checks++;
        if (alu_res !== 16'd3) begin
            failures++; $display("FAIL add_result: got %0d required 3", alu_res);
        end
    endtask

    task automatic test_slt();
        int bad;
        wait_ph(6);
        a_val = 16'd5; b_val = 16'd7;
        op_valid = 1'b1; op_code = 3'd2;
        tick();
        op_valid = 1'b0;
        wait_ph(0);
        tick();
        checks++;
        if (ctrl !== 10'b1011111100) begin
            failures++; $display("FAIL slt_ctrl: got %b required 1011111100", ctrl);
        end
        bad = 0;
        for (int i = 0; i < P - 1; i++) begin
            tick();
            if (ctrl[4:2] !== 3'b111) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL slt_hold: unstable cycles=%0d required 0", bad);
        end
        tick();
        checks++;
        if (done !== 1'b1 || missed !== 1'b0) begin
            failures++; $display("FAIL slt_done: done=%b missed=%b required 1 0", done, missed);
        end
        checks++;
        if (alu_res !== 16'd1) begin
            failures++; $display("FAIL slt_result: got %0d required 1", alu_res);
        end
    endtask

    task automatic test_hold2();
        int p0, d0;
        wait_ph(4);
        op_valid2 = 1'b1; op_code2 = 3'd4;
        tick();
        op_valid2 = 1'b0;
        wait_ph(0);
        p0 = pulse2_cnt;
        d0 = done2_cnt;
        tick();
        checks++;
        if (ctrl2 !== 10'b0111100000) begin
            failures++; $display("FAIL hold2_ctrl: got %b required 0111100000", ctrl2);
        end
        wait_ph(5);
        op_valid2 = 1'b1; op_code2 = 3'd7;
        tick();
        op_valid2 = 1'b0;
        wait_ph(0);
        tick();
        checks++;
        if (done2 !== 1'b0 || ctrl2 !== 10'b0111100000 || busy2 !== 1'b1) begin
            failures++; $display("FAIL hold2_first_rise: done=%b ctrl=%b busy=%b required 0 0111100000 1", done2, ctrl2, busy2);
        end
        wait_ph(0);
        tick();
        checks++;
        if (done2 !== 1'b1 || missed2 !== 1'b0 || ctrl2 !== 10'd0) begin
            failures++; $display("FAIL hold2_done: done=%b missed=%b ctrl=%b required 1 0 0", done2, missed2, ctrl2);
        end
        checks++;
        if (pulse2_cnt - p0 != 1) begin
            failures++; $display("FAIL hold2_pulses: got %0d required 1", pulse2_cnt - p0);
        end
        repeat (2 * P) tick();
        checks++;
        if (done2_cnt - d0 != 1 || busy2 !== 1'b0 || op_ready2 !== 1'b1 || ctrl2 !== 10'd0) begin
            failures++; $display("FAIL hold2_ignored: dones=%0d busy=%b ready=%b required 1 0 1", done2_cnt - d0, busy2, op_ready2);
        end
    endtask

    task automatic test_missed_peak();
        int p0;
        wait_ph(3);
        hole = 1'b1;
        op_valid = 1'b1; op_code = 3'd5;
        tick();
        op_valid = 1'b0;
        wait_ph(0);
        p0 = pulse_cnt;
        tick();
        checks++;
        if (ctrl !== 10'b1101100000) begin
            failures++; $display("FAIL passb_ctrl: got %b required 1101100000", ctrl);
        end
        wait_ph(0);
        tick();
        checks++;
        if (done !== 1'b1 || missed !== 1'b1) begin
            failures++; $display("FAIL missed_done: done=%b missed=%b required 1 1", done, missed);
        end
        checks++;
        if (pulse_cnt != p0) begin
            failures++; $display("FAIL missed_pulses: got %0d required 0", pulse_cnt - p0);
        end
        hole = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        int d0, p0, bad;
        wait_ph(4);
        op_valid = 1'b1; op_code = 3'd7;
        tick();
        op_valid = 1'b0;
        wait_ph(0);
        tick();
        checks++;
        if (ctrl !== 10'b1100000010) begin
            failures++; $display("FAIL imm_ctrl: got %b required 1100000010", ctrl);
        end
        wait_ph(5);
        d0 = done_cnt;
        p0 = pulse_cnt;
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl !== 10'd0 || busy !== 1'b0 || op_ready !== 1'b1) begin
            failures++; $display("FAIL async_reset: ctrl=%b busy=%b ready=%b required 0 0 1", ctrl, busy, op_ready);
        end
        wait_ph(0);
        reset = 1'b0;
        op_valid = 1'b1; op_code = 3'd3;
        tick();
        op_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < P - 1; i++) begin
            if (ctrl !== 10'd0 || busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL release_no_arm: bad cycles=%0d required 0", bad);
        end
        checks++;
        if (done_cnt != d0 || pulse_cnt != p0) begin
            failures++; $display("FAIL reset_no_done: dones=%0d pulses=%0d required 0 0", done_cnt - d0, pulse_cnt - p0);
        end
        tick();
        checks++;
        if (ctrl !== 10'b0011100000) begin
            failures++; $display("FAIL and_after_reset: got %b required 0011100000", ctrl);
        end
        wait_ph(0);
        tick();
        checks++;
        if (done !== 1'b1 || missed !== 1'b0) begin
            failures++; $display("FAIL and_done: done=%b missed=%b required 1 0", done, missed);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt();
        test_hold2();
        test_missed_peak();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
